// File: rtl/tcm3_pkg.sv
// Shared constants, state encoding and limb-pair schedule for the tcm3 serial GF(2) multiplier.
package tcm3_pkg;

    localparam int A_W     = 233;
    localparam int LIMB_W  = 78;
    localparam int CNT_W   = 7;
    localparam int C_W     = 466;
    localparam int PROD_W  = 155;
    localparam int N_PAIRS = 9;
    localparam int OFF0    = 0;
    localparam int OFF1    = 78;
    localparam int OFF2    = 155;
    localparam int P_W     = 4;
    localparam int SH_W    = 9;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    typedef struct packed {
        logic [1:0]      i;
        logic [1:0]      j;
        logic [SH_W-1:0] shift;
    } pair_t;

    function automatic logic [SH_W-1:0] limb_off(input logic [1:0] k);
        case (k)
            2'd1:    return SH_W'(OFF1);
            2'd2:    return SH_W'(OFF2);
            default: return SH_W'(OFF0);
        endcase
    endfunction

    // Pair p -> (p/3, p%3); indices past the last pair map to (0,0) so a
    // look-ahead on p+1 never selects a nonexistent limb.
    function automatic pair_t pair_map(input logic [P_W-1:0] p);
        pair_t r;
        r.i = 2'd0;
        r.j = 2'd0;
        if (p < P_W'(N_PAIRS)) begin
            r.i = 2'(p / P_W'(3));
            r.j = 2'(p % P_W'(3));
        end
        r.shift = limb_off(r.i) + limb_off(r.j);
        return r;
    endfunction

endpackage

// File: rtl/tcm3_serial_scheduler_mul.sv
// Bit-serial 78x78 carry-less shift-XOR engine: one multiplier bit per cycle after start.
module gf2_serial_mul_78
    import tcm3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LIMB_W-1:0] ai,
    input  logic [LIMB_W-1:0] bj,
    output logic [PROD_W-1:0] prod,
    output logic              last
);

    logic [CNT_W-1:0] cnt;
    logic             run;

    assign last = run && (cnt == CNT_W'(LIMB_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            run  <= 1'b0;
            prod <= '0;
        end else if (start) begin
            cnt  <= '0;
            run  <= 1'b1;
            prod <= '0;
        end else if (run) begin
            if (ai[cnt])
                prod <= prod ^ (PROD_W'(bj) << cnt);
            cnt <= cnt + 1'b1;
            if (last)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/tcm3_serial_scheduler.sv
// Area-reduced 233x233 GF(2) multiplier: nine limb products through one serial engine.
// Optional build macro TCM_SKIP_ZERO_EN skips pairs with a zero limb (variable latency).
module tcm3_serial_scheduler
    import tcm3_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [C_W-1:0] c,
    output logic           busy
);

    state_t                 state, next_state;
    logic [2:0][LIMB_W-1:0] al, bl;
    logic [P_W-1:0]         p;
    logic [C_W-1:0]         acc, c_q;
    logic                   out_valid_q;
    pair_t                  cur;
    logic [LIMB_W-1:0]      ai, bj;
    logic [PROD_W-1:0]      prod;
    logic                   mul_last, start, accept, last_pair;
    logic                   skip_first, skip_next;

    assign cur       = pair_map(p);
    assign ai        = al[cur.i];
    assign bj        = bl[cur.j];
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_pair = (p == P_W'(N_PAIRS - 1));
    assign out_valid = out_valid_q;
    assign c         = c_q;

`ifdef TCM_SKIP_ZERO_EN
    pair_t nxt;
    assign nxt        = pair_map(p + 1'b1);
    assign skip_first = (a[LIMB_W-1:0] == '0) || (b[LIMB_W-1:0] == '0);
    assign skip_next  = (al[nxt.i] == '0) || (bl[nxt.j] == '0);
`else
    assign skip_first = 1'b0;
    assign skip_next  = 1'b0;
`endif

    // A skipped pair still restarts the engine: prod is cleared and any
    // stepping only XORs in a zero limb, so ACC sees prod == 0.
    gf2_serial_mul_78 u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ai    (ai),
        .bj    (bj),
        .prod  (prod),
        .last  (mul_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = skip_first ? ACC : MUL;
                    start      = 1'b1;
                end
            end
            MUL: begin
                if (mul_last)
                    next_state = ACC;
            end
            ACC: begin
                if (last_pair) begin
                    next_state = DONE;
                end else begin
                    next_state = skip_next ? ACC : MUL;
                    start      = 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // DONE spends its first cycle publishing acc into c, giving 9*79+1 latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            al          <= '0;
            bl          <= '0;
            p           <= '0;
            acc         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                al[0] <= a[LIMB_W-1:0];
                al[1] <= {1'b0, a[OFF2-1:OFF1]};
                al[2] <= a[A_W-1:OFF2];
                bl[0] <= b[LIMB_W-1:0];
                bl[1] <= {1'b0, b[OFF2-1:OFF1]};
                bl[2] <= b[A_W-1:OFF2];
                acc   <= '0;
                p     <= '0;
            end
            if (state == ACC) begin
                acc <= acc ^ (C_W'(prod) << cur.shift);
                if (!last_pair)
                    p <= p + 1'b1;
            end
            if (state == DONE && !out_valid_q) begin
                out_valid_q <= 1'b1;
                c_q         <= acc;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
